// File: rtl/mcb_pkg.sv
// Shared MCB user-port definitions: command encodings, widths, sequencer states
// and the latched requester descriptor.
package mcb_pkg;
  localparam logic [2:0] MCB_CMD_WRITE  = 3'b000;
  localparam logic [2:0] MCB_CMD_READ   = 3'b001;
  localparam logic [2:0] MCB_CMD_READPC = 3'b011;

  localparam int MCB_WORD_W = 128;
  localparam int MCB_MASK_W = 16;
  localparam int MCB_ADDR_W = 30;

  // Commands are whole-word, so the low nibble of the byte address is dropped.
  localparam logic [MCB_ADDR_W-1:0] MCB_WORD_ADDR_MASK = ~30'hF;

  typedef enum logic [2:0] {
    IDLE, WR_PUSH, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT, RD_POP, DONE
  } mcb_state_e;

  typedef struct packed {
    logic                  we;
    logic [MCB_ADDR_W-1:0] addr;
    logic [MCB_WORD_W-1:0] wdata;
    logic [MCB_MASK_W-1:0] wmask;
  } mcb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. On a tie the requester not served last wins;
// the history only moves when the client signals completion via upd.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       gnt_vld,
  output logic       gnt_id
);
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last <= 1'b1;
    else if (upd) last <= upd_id;
  end

  always_comb begin
    gnt_vld = |req;
    if (&req) gnt_id = ~last;
    else      gnt_id = req[1];
  end
endmodule

// File: rtl/mcb_port_arb.sv
// Arbitrates two single-word clients onto MCB port 0 and sequences the
// write-FIFO / command / read-FIFO handshakes with a per-state timeout.
module mcb_port_arb
  import mcb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  calib_done,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [MCB_ADDR_W-1:0] a_addr,
  input  logic [MCB_WORD_W-1:0] a_wdata,
  input  logic [MCB_MASK_W-1:0] a_wmask,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [MCB_ADDR_W-1:0] b_addr,
  input  logic [MCB_WORD_W-1:0] b_wdata,
  input  logic [MCB_MASK_W-1:0] b_wmask,
  output logic                  b_ack,
  output logic [MCB_WORD_W-1:0] rdata,
  output logic                  err,
  output logic                  cmd_en,
  output logic [2:0]            cmd_instr,
  output logic [5:0]            cmd_bl,
  output logic [MCB_ADDR_W-1:0] cmd_byte_addr,
  input  logic                  cmd_full,
  output logic                  wr_en,
  output logic [MCB_WORD_W-1:0] wr_data,
  output logic [MCB_MASK_W-1:0] wr_mask,
  input  logic                  wr_full,
  input  logic                  wr_empty,
  input  logic                  wr_underrun,
  input  logic                  wr_error,
  output logic                  rd_en,
  input  logic [MCB_WORD_W-1:0] rd_data,
  input  logic                  rd_empty,
  input  logic                  rd_overflow,
  input  logic                  rd_error
);
  localparam int CW = $clog2(TIMEOUT + 1);

  mcb_state_e    state, state_nxt;
  mcb_req_t      req_q, req_sel;
  logic          cur_id;
  logic          gnt_vld, gnt_id;
  logic [CW-1:0] cnt;
  logic          ld_req, do_wr, do_cmd, do_rd, upd, to_hit, waiting, tmo;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({b_req, a_req}),
    .upd     (upd),
    .upd_id  (cur_id),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    if (gnt_id) req_sel = {b_we, b_addr, b_wdata, b_wmask};
    else        req_sel = {a_we, a_addr, a_wdata, a_wmask};
  end

  assign waiting = state inside {WR_PUSH, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT};
  assign tmo     = (cnt == CW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    ld_req    = 1'b0;
    do_wr     = 1'b0;
    do_cmd    = 1'b0;
    do_rd     = 1'b0;
    upd       = 1'b0;
    to_hit    = 1'b0;
    case (state)
      // A req seen during the ack cycle is the old one; only the next cycle counts.
      IDLE: if (calib_done && gnt_vld && !(a_ack || b_ack)) begin
        ld_req    = 1'b1;
        state_nxt = req_sel.we ? WR_PUSH : RD_CMD;
      end
      WR_PUSH: if (!wr_full) begin
        do_wr     = 1'b1;
        state_nxt = WR_CMD;
      end
      WR_CMD: if (!cmd_full) begin
        do_cmd    = 1'b1;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: if (wr_empty) state_nxt = DONE;
      RD_CMD: if (!cmd_full) begin
        do_cmd    = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: if (!rd_empty) begin
        do_rd     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        upd       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = DONE;
    endcase
    // Progress wins over the timeout when both land in the same cycle.
    if (waiting && state_nxt == state && tmo) begin
      to_hit    = 1'b1;
      state_nxt = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      req_q  <= '0;
      cur_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (waiting)       cnt <= cnt + CW'(1);
      if (ld_req) begin
        req_q  <= req_sel;
        cur_id <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_en        <= 1'b0;
      cmd_instr     <= '0;
      cmd_byte_addr <= '0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
      wr_mask       <= '0;
      rd_en         <= 1'b0;
      rdata         <= '0;
      a_ack         <= 1'b0;
      b_ack         <= 1'b0;
      err           <= 1'b0;
    end else begin
      cmd_en <= do_cmd;
      wr_en  <= do_wr;
      rd_en  <= do_rd;
      a_ack  <= upd & ~cur_id;
      b_ack  <= upd & cur_id;
      err    <= err | to_hit | wr_underrun | rd_overflow | wr_error | rd_error;
      if (do_cmd) begin
        cmd_instr     <= (state == RD_CMD) ? MCB_CMD_READ : MCB_CMD_WRITE;
        cmd_byte_addr <= req_q.addr & MCB_WORD_ADDR_MASK;
      end
      if (do_wr) begin
        wr_data <= req_q.wdata;
        wr_mask <= req_q.wmask;
      end
      if (do_rd) rdata <= rd_data;
    end
  end

  assign cmd_bl = 6'd0;
endmodule
